// File: rtl/umem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, transaction owners
// and the store-size encoding used by the LSU.
package umem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RD_WAIT
    } arb_state_e;

    typedef enum logic [1:0] {
        NONE,
        IF,
        LD,
        ST
    } owner_e;

    localparam logic [1:0] ST_BYTE = 2'b00;
    localparam logic [1:0] ST_HALF = 2'b01;
    localparam logic [1:0] ST_WORD = 2'b10;

endpackage

// File: rtl/umem_be_gen.sv
// Byte-enable generator: store size and byte offset to a 4-lane write mask.
// Encoding 2'b11 is treated as a full word.
module umem_be_gen
    import umem_arb_pkg::*;
(
    input  logic [1:0] store_type_i,
    input  logic [1:0] offset_i,
    output logic [3:0] be_o
);

    always_comb begin
        case (store_type_i)
            ST_BYTE: be_o = 4'b0001 << offset_i;
            ST_HALF: be_o = 4'b0011 << {offset_i[1], 1'b0};
            default: be_o = 4'b1111;
        endcase
    end

endmodule

// File: rtl/umem_port_arb.sv
// Arbiter sharing one single-port memory between instruction fetch and load/store.
// Define UMEM_ARB_PERF_EN to add the conflict / forced-fetch performance counters.
module umem_port_arb
    import umem_arb_pkg::*;
#(
    parameter int AW               = 32,
    parameter int FETCH_STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    output logic          if_stall,
    input  logic          ls_rd_en,
    input  logic [AW-1:0] ls_rd_addr,
    input  logic          ls_wr_en,
    input  logic [AW-1:0] ls_wr_addr,
    input  logic [31:0]   ls_wr_data,
    input  logic [1:0]    ls_store_type,
    input  logic [1:0]    ls_store_offset,
    output logic          ls_rvalid,
    output logic [31:0]   ls_rdata,
    output logic          ls_wr_done,
    output logic          ls_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata
`ifdef UMEM_ARB_PERF_EN
    ,
    output logic [31:0]   perf_conflict_cnt,
    output logic [31:0]   perf_starve_cnt
`endif
);

    localparam int            SW         = $clog2(FETCH_STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(FETCH_STARVE_MAX);

    arb_state_e    state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic          we_q, we_d;
    logic          drop_q, drop_d;
    logic [SW-1:0] starve_q, starve_d;

    logic [3:0] st_be;
    logic       data_pend;
    logic       force_fetch;
    logic       grant_if;
    logic       grant_data;
    logic       unused_addr_lsbs;

    assign data_pend        = ls_rd_en | ls_wr_en;
    assign force_fetch      = if_req && (starve_q == STARVE_MAX);
    assign unused_addr_lsbs = ^{if_addr[1:0], ls_rd_addr[1:0], ls_wr_addr[1:0]};

    umem_be_gen u_be_gen (
        .store_type_i (ls_store_type),
        .offset_i     (ls_store_offset),
        .be_o         (st_be)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        drop_d     = drop_q;
        starve_d   = starve_q;
        grant_if   = 1'b0;
        grant_data = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_be     = '0;
        if_rvalid  = 1'b0;
        if_rdata   = '0;
        ls_rvalid  = 1'b0;
        ls_rdata   = '0;
        ls_wr_done = 1'b0;

        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (ls_wr_en && !force_fetch) begin
                    grant_data = 1'b1;
                    owner_d    = ST;
                    we_d       = 1'b1;
                    addr_d     = {ls_wr_addr[AW-1:2], 2'b00};
                    wdata_d    = ls_wr_data;
                    be_d       = st_be;
                    state_d    = REQ;
                end else if (ls_rd_en && !force_fetch) begin
                    grant_data = 1'b1;
                    owner_d    = LD;
                    we_d       = 1'b0;
                    addr_d     = {ls_rd_addr[AW-1:2], 2'b00};
                    wdata_d    = '0;
                    be_d       = '0;
                    state_d    = REQ;
                end else if (if_req) begin
                    grant_if = 1'b1;
                    owner_d  = IF;
                    we_d     = 1'b0;
                    addr_d   = {if_addr[AW-1:2], 2'b00};
                    wdata_d  = '0;
                    be_d     = '0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_be    = be_q;
                if (owner_q == IF && if_flush) drop_d = 1'b1;
                if (mem_gnt) begin
                    if (we_q) begin
                        ls_wr_done = 1'b1;
                        owner_d    = NONE;
                        drop_d     = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (owner_q == IF && if_flush) drop_d = 1'b1;
                if (mem_rvalid) begin
                    // A flush in the completing cycle also discards the response.
                    if (owner_q == IF && !(drop_q || if_flush)) begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                    end
                    if (owner_q == LD) begin
                        ls_rvalid = 1'b1;
                        ls_rdata  = mem_rdata;
                    end
                    owner_d = NONE;
                    drop_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                owner_d = NONE;
                state_d = IDLE;
            end
        endcase

        if (!if_req || grant_if) begin
            starve_d = '0;
        end else if (grant_data && starve_q != STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
        end

        // Reset abandons the transaction at once: nothing is requested or completed.
        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            mem_addr   = '0;
            mem_wdata  = '0;
            mem_be     = '0;
            if_rvalid  = 1'b0;
            if_rdata   = '0;
            ls_rvalid  = 1'b0;
            ls_rdata   = '0;
            ls_wr_done = 1'b0;
        end

        if_stall = if_req & ~if_rvalid;
        ls_stall = data_pend & ~ls_rvalid & ~ls_wr_done;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= NONE;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            we_q     <= 1'b0;
            drop_q   <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            we_q     <= we_d;
            drop_q   <= drop_d;
            starve_q <= starve_d;
        end
    end

`ifdef UMEM_ARB_PERF_EN
    logic [31:0] perf_conflict_q;
    logic [31:0] perf_starve_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_conflict_q <= '0;
            perf_starve_q   <= '0;
        end else begin
            if (state_q == IDLE && if_req && data_pend) perf_conflict_q <= perf_conflict_q + 32'd1;
            if (state_q == IDLE && force_fetch)         perf_starve_q   <= perf_starve_q + 32'd1;
        end
    end

    assign perf_conflict_cnt = perf_conflict_q;
    assign perf_starve_cnt   = perf_starve_q;
`endif

endmodule

// File: tb/tb_umem_port_arb.sv
// Self-checking bench for umem_port_arb: a latency-programmable memory model with a
// transaction scoreboard, plus per-port response scoreboards.
module tb_umem_port_arb;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_rvalid, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        ls_rd_en, ls_wr_en, ls_rvalid, ls_wr_done, ls_stall;
    logic [31:0] ls_rd_addr, ls_wr_addr, ls_wr_data, ls_rdata;
    logic [1:0]  ls_store_type, ls_store_offset;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
`ifdef UMEM_ARB_PERF_EN
    logic [31:0] perf_conflict_cnt, perf_starve_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    mem_txn_t    exp_mem[$];
    logic [31:0] exp_if[$];
    logic [31:0] exp_ls[$];
    logic [31:0] exp_wr[$];

    int          gnt_delay = 0;
    int          rv_delay  = 1;
    int          wait_cnt  = 0;
    int          rv_cnt    = 0;
    logic        rv_pending = 1'b0;
    logic [31:0] rv_addr   = '0;
    int          last_gnt_cyc = -1;
    int          last_if_rv_cyc = -1;
    int          last_ls_rv_cyc = -1;
    int          if_rv_cnt = 0;
    int          ls_rv_cnt = 0;

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    umem_port_arb #(.AW(32), .FETCH_STARVE_MAX(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .if_req          (if_req),
        .if_addr         (if_addr),
        .if_flush        (if_flush),
        .if_rvalid       (if_rvalid),
        .if_rdata        (if_rdata),
        .if_stall        (if_stall),
        .ls_rd_en        (ls_rd_en),
        .ls_rd_addr      (ls_rd_addr),
        .ls_wr_en        (ls_wr_en),
        .ls_wr_addr      (ls_wr_addr),
        .ls_wr_data      (ls_wr_data),
        .ls_store_type   (ls_store_type),
        .ls_store_offset (ls_store_offset),
        .ls_rvalid       (ls_rvalid),
        .ls_rdata        (ls_rdata),
        .ls_wr_done      (ls_wr_done),
        .ls_stall        (ls_stall),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_be          (mem_be),
        .mem_gnt         (mem_gnt),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata)
`ifdef UMEM_ARB_PERF_EN
        ,
        .perf_conflict_cnt (perf_conflict_cnt),
        .perf_starve_cnt   (perf_starve_cnt)
`endif
    );

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hC3A5_5A3C;
    endfunction

    // Memory model: grant after gnt_delay cycles of mem_req, read data rv_delay cycles after grant.
    task automatic mem_model();
        mem_txn_t e;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (rv_pending) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdata_of(rv_addr);
                rv_pending = 1'b0;
            end
        end
        if (mem_req) begin
            if (wait_cnt >= gnt_delay) begin
                mem_gnt      = 1'b1;
                wait_cnt     = 0;
                last_gnt_cyc = cyc;
                n_checks++;
                if (exp_mem.size() == 0) begin
                    $display("FAIL mem_txn: unexpected request we=%0b addr=%h be=%b (none required)",
                             mem_we, mem_addr, mem_be);
                end else begin
                    e = exp_mem.pop_front();
                    if (mem_we !== e.we || mem_addr !== e.addr || mem_be !== e.be ||
                        (e.we && mem_wdata !== e.wdata))
                        $display("FAIL mem_txn: got we=%0b addr=%h be=%b wdata=%h, required we=%0b addr=%h be=%b wdata=%h",
                                 mem_we, mem_addr, mem_be, mem_wdata, e.we, e.addr, e.be, e.wdata);
                    else
                        n_pass++;
                end
                if (!mem_we) begin
                    rv_pending = 1'b1;
                    rv_cnt     = rv_delay;
                    rv_addr    = mem_addr;
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    endtask

    task automatic monitor();
        logic [31:0] e;
        if (if_rvalid) begin
            if_rv_cnt++;
            last_if_rv_cyc = cyc;
            n_checks++;
            if (exp_if.size() == 0) begin
                $display("FAIL if_resp: unexpected if_rvalid data=%h (none required)", if_rdata);
            end else begin
                e = exp_if.pop_front();
                if (if_rdata !== e) $display("FAIL if_resp: got %h required %h", if_rdata, e);
                else n_pass++;
            end
        end
        if (ls_rvalid) begin
            ls_rv_cnt++;
            last_ls_rv_cyc = cyc;
            n_checks++;
            if (exp_ls.size() == 0) begin
                $display("FAIL ls_resp: unexpected ls_rvalid data=%h (none required)", ls_rdata);
            end else begin
                e = exp_ls.pop_front();
                if (ls_rdata !== e) $display("FAIL ls_resp: got %h required %h", ls_rdata, e);
                else n_pass++;
            end
        end
        if (ls_wr_done) begin
            n_checks++;
            if (exp_wr.size() == 0) begin
                $display("FAIL wr_done: unexpected pulse at addr %h (none required)", mem_addr);
            end else begin
                e = exp_wr.pop_front();
                if (mem_addr !== e) $display("FAIL wr_done: addr got %h required %h", mem_addr, e);
                else n_pass++;
            end
        end
    endtask

    // Each cycle: drive at posedge+1, sample() at negedge+1, then next().
    task automatic sample();
        @(negedge clk);
        mem_model();
        #1;
        monitor();
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic expect_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wdata);
        mem_txn_t t;
        t.we = we; t.addr = addr; t.be = be; t.wdata = wdata;
        exp_mem.push_back(t);
    endtask

    task automatic drive_fetch(input logic [31:0] addr);
        if_req  = 1'b1;
        if_addr = addr;
        exp_if.push_back(rdata_of(addr));
    endtask

    task automatic drive_load(input logic [31:0] addr);
        ls_rd_en   = 1'b1;
        ls_rd_addr = addr;
        exp_ls.push_back(rdata_of(addr));
    endtask

    task automatic drive_store(input logic [31:0] addr, input logic [31:0] data,
                               input logic [1:0] st, input logic [1:0] off);
        ls_wr_en        = 1'b1;
        ls_wr_addr      = addr;
        ls_wr_data      = data;
        ls_store_type   = st;
        ls_store_offset = off;
        exp_wr.push_back({addr[31:2], 2'b00});
    endtask

    task automatic serve(input string name, input int budget);
        int   n;
        logic d_if, d_ld, d_st;
        n = 0;
        while ((if_req || ls_rd_en || ls_wr_en) && n < budget) begin
            sample();
            d_if = if_rvalid;
            d_ld = ls_rvalid;
            d_st = ls_wr_done;
            next();
            if (d_if) if_req = 1'b0;
            if (d_ld) ls_rd_en = 1'b0;
            if (d_st) ls_wr_en = 1'b0;
            n++;
        end
        n_checks++;
        if (if_req || ls_rd_en || ls_wr_en)
            $display("FAIL %s: requests still pending after %0d cycles, required all served", name, budget);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req = 0; if_addr = 0; if_flush = 0;
        ls_rd_en = 0; ls_rd_addr = 0; ls_wr_en = 0; ls_wr_addr = 0; ls_wr_data = 0;
        ls_store_type = 0; ls_store_offset = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        next();
        sample();
        n_checks++;
        if ({mem_req, mem_we, mem_be, if_rvalid, ls_rvalid, ls_wr_done, if_stall, ls_stall} !== 11'b0)
            $display("FAIL reset_ctrl: got req=%b we=%b be=%b ifv=%b lsv=%b wd=%b ifs=%b lss=%b, required all 0",
                     mem_req, mem_we, mem_be, if_rvalid, ls_rvalid, ls_wr_done, if_stall, ls_stall);
        else n_pass++;
        n_checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || if_rdata !== 32'h0 || ls_rdata !== 32'h0)
            $display("FAIL reset_data: got addr=%h wdata=%h if_rdata=%h ls_rdata=%h, required 0",
                     mem_addr, mem_wdata, if_rdata, ls_rdata);
        else n_pass++;
`ifdef UMEM_ARB_PERF_EN
        n_checks++;
        if (perf_conflict_cnt !== 32'd0 || perf_starve_cnt !== 32'd0)
            $display("FAIL reset_perf: got %0d/%0d required 0/0", perf_conflict_cnt, perf_starve_cnt);
        else n_pass++;
`endif
        next();
        if_req = 1'b1;
        ls_wr_en = 1'b1;
        sample();
        n_checks++;
        if (if_stall !== 1'b1 || ls_stall !== 1'b1 || mem_req !== 1'b0)
            $display("FAIL reset_stall: got if_stall=%b ls_stall=%b mem_req=%b, required 1 1 0",
                     if_stall, ls_stall, mem_req);
        else n_pass++;
        next();
        if_req = 1'b0;
        ls_wr_en = 1'b0;
        rst = 1'b0;
        next();
    endtask

    task automatic test_fetch_only();
        int c0;
        gnt_delay = 0; rv_delay = 1;
        c0 = cyc;
        expect_txn(1'b0, 32'h100, 4'b0000, '0);
        drive_fetch(32'h100);
        sample();
        n_checks++;
        if (if_stall !== 1'b1 || mem_req !== 1'b0)
            $display("FAIL fetch_c0: got if_stall=%b mem_req=%b required 1 0", if_stall, mem_req);
        else n_pass++;
        next();
        sample();
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_be !== 4'b0 || if_stall !== 1'b1)
            $display("FAIL fetch_c1: got req=%b addr=%h be=%b stall=%b required 1 00000100 0000 1",
                     mem_req, mem_addr, mem_be, if_stall);
        else n_pass++;
        next();
        sample();
        n_checks++;
        if (if_rvalid !== 1'b1 || if_stall !== 1'b0 || last_if_rv_cyc != c0 + 2)
            $display("FAIL fetch_c2: got rvalid=%b stall=%b at cycle +%0d required 1 0 at +2",
                     if_rvalid, if_stall, last_if_rv_cyc - c0);
        else n_pass++;
        next();
        if_req = 1'b0;
        next();
    endtask

    task automatic test_priority();
        expect_txn(1'b0, 32'h2000, 4'b0000, '0);
        expect_txn(1'b0, 32'h3000, 4'b0000, '0);
        drive_load(32'h2000);
        drive_fetch(32'h3000);
        serve("priority", 40);
        n_checks++;
        if (last_gnt_cyc != last_ls_rv_cyc + 2)
            $display("FAIL priority_gap: fetch granted %0d cycles after ls_rvalid, required 2",
                     last_gnt_cyc - last_ls_rv_cyc);
        else n_pass++;
        next();
    endtask

    task automatic test_starvation();
        int   c0, n, sent;
        logic d_if, d_st;
        c0 = cyc;
        for (int i = 0; i < 4; i++) expect_txn(1'b1, 32'h400 + 32'(4 * i), 4'b1111, 32'h1111_0000 + 32'(i));
        expect_txn(1'b0, 32'h500, 4'b0000, '0);
        expect_txn(1'b1, 32'h410, 4'b1111, 32'h1111_0004);
        drive_store(32'h400, 32'h1111_0000, 2'b10, 2'b00);
        drive_fetch(32'h500);
        sent = 1;
        n = 0;
        while ((if_req || ls_wr_en) && n < 60) begin
            sample();
            d_if = if_rvalid;
            d_st = ls_wr_done;
            next();
            if (d_st) begin
                if (sent < 5) begin
                    drive_store(32'h400 + 32'(4 * sent), 32'h1111_0000 + 32'(sent), 2'b10, 2'b00);
                    sent++;
                end else begin
                    ls_wr_en = 1'b0;
                end
            end
            if (d_if) if_req = 1'b0;
            n++;
        end
        n_checks++;
        if (if_req || ls_wr_en) $display("FAIL starve_done: requests pending after 60 cycles, required none");
        else n_pass++;
        n_checks++;
        if (last_if_rv_cyc != c0 + 10)
            $display("FAIL starve_fetch: fetch data at cycle +%0d required +10", last_if_rv_cyc - c0);
        else n_pass++;
`ifdef UMEM_ARB_PERF_EN
        n_checks++;
        if (perf_starve_cnt !== 32'd1) $display("FAIL perf_starve: got %0d required 1", perf_starve_cnt);
        else n_pass++;
`endif
        next();
    endtask

    task automatic test_store_be();
        logic [1:0]  st_tab [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b00};
        logic [1:0]  off_tab[6] = '{2'd3,  2'd2,  2'd0,  2'd1,  2'd0,  2'd0};
        logic [3:0]  be_tab [6] = '{4'b1000, 4'b1100, 4'b1111, 4'b1111, 4'b0011, 4'b0001};
        for (int i = 0; i < 6; i++) begin
            expect_txn(1'b1, 32'h200, be_tab[i], 32'hA000_0000 + 32'(i));
            drive_store(32'h200 | 32'(off_tab[i]), 32'hA000_0000 + 32'(i), st_tab[i], off_tab[i]);
            serve("store_be", 20);
        end
    endtask

    task automatic test_back_to_back();
        expect_txn(1'b1, 32'h800, 4'b1111, 32'h5555_AAAA);
        expect_txn(1'b0, 32'h900, 4'b0000, '0);
        drive_store(32'h800, 32'h5555_AAAA, 2'b10, 2'b00);
        drive_load(32'h900);
        sample();
        n_checks++;
        if (ls_stall !== 1'b1) $display("FAIL b2b_stall: got ls_stall=%b required 1", ls_stall);
        else n_pass++;
        next();
        serve("back_to_back", 30);
        next();
    endtask

    task automatic test_flush();
        int c0, rv0;
        c0 = cyc;
        rv0 = if_rv_cnt;
        gnt_delay = 0; rv_delay = 3;
        expect_txn(1'b0, 32'h600, 4'b0000, '0);
        expect_txn(1'b0, 32'h640, 4'b0000, '0);
        if_req = 1'b1;
        if_addr = 32'h600;
        sample(); next();
        sample(); next();
        if_flush = 1'b1;
        if_addr = 32'h640;
        exp_if.push_back(rdata_of(32'h640));
        sample(); next();
        if_flush = 1'b0;
        rv_delay = 1;
        serve("flush", 30);
        n_checks++;
        if (if_rv_cnt - rv0 != 1 || last_if_rv_cyc != c0 + 7)
            $display("FAIL flush_resp: got %0d pulses, last at +%0d, required 1 pulse at +7",
                     if_rv_cnt - rv0, last_if_rv_cyc - c0);
        else n_pass++;
        next();
    endtask

    task automatic test_reset_mid();
        int rv0;
        rv0 = ls_rv_cnt;
        gnt_delay = 0; rv_delay = 3;
        expect_txn(1'b0, 32'h700, 4'b0000, '0);
        ls_rd_en = 1'b1;
        ls_rd_addr = 32'h700;
        sample(); next();
        sample(); next();
        rst = 1'b1;
        ls_rd_en = 1'b0;
        sample();
        n_checks++;
        if (mem_req !== 1'b0 || ls_rvalid !== 1'b0)
            $display("FAIL rst_mid: got mem_req=%b ls_rvalid=%b required 0 0", mem_req, ls_rvalid);
        else n_pass++;
        next();
        rst = 1'b0;
        rv_delay = 1;
        sample(); next();
        sample();
        n_checks++;
        if (mem_rvalid !== 1'b1 || ls_rvalid !== 1'b0 || if_rvalid !== 1'b0)
            $display("FAIL rst_stale: got mem_rvalid=%b ls_rvalid=%b if_rvalid=%b required 1 0 0",
                     mem_rvalid, ls_rvalid, if_rvalid);
        else n_pass++;
        next();
        expect_txn(1'b0, 32'h740, 4'b0000, '0);
        drive_load(32'h740);
        serve("rst_recover", 20);
        n_checks++;
        if (ls_rv_cnt - rv0 != 1) $display("FAIL rst_count: got %0d load pulses required 1", ls_rv_cnt - rv0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_priority();
        test_starvation();
        test_store_be();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        repeat (4) begin
            sample();
            next();
        end
        n_checks++;
        if (exp_mem.size() != 0 || exp_if.size() != 0 || exp_ls.size() != 0 || exp_wr.size() != 0)
            $display("FAIL drain: left mem=%0d if=%0d ls=%0d wr=%0d required all 0",
                     exp_mem.size(), exp_if.size(), exp_ls.size(), exp_wr.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
